add_round_key_stage: RTL and testbench
======================================

Name: add_round_key_stage

Overview:
- Registered AddRoundKey stage for AES-128 encryption. It sits directly downstream of mixColumns and also takes the ShiftRows output for the final round.
- Holds the cipher key and generates round keys 0..10 on the fly, one step per accepted state.
- XORs each incoming 4x4 state matrix with the current round key.
- Presents the result behind a valid/ready output register, which feeds the next round's SubBytes or the ciphertext sink.

Parameters:
- NR, 10, number of AES rounds; fixed at 10 for AES-128, other values unsupported.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous active-high reset.
- key_load  input  1  load new cipher key this cycle.
- key_in  input  128  cipher key; key_in[127:120] is key byte 0.
- in_valid  input  1  state_matrix holds a valid round state.
- in_ready  output  1  stage accepts the state this cycle.
- state_matrix  input  8x[0:3][0:3]  state[row][col]; byte index = 4*col+row.
- out_valid  output  1  mixed_out is valid.
- out_ready  input  1  downstream accepts mixed_out.
- mixed_out  output  8x[0:3][0:3]  state XOR round key, registered.
- out_round  output  4  round index (0..10) applied to mixed_out.
- out_last  output  1  mixed_out is final ciphertext (round 10).
- key_valid  output  1  a cipher key has been loaded.

Behaviour:
- Reset: key_valid=0, out_valid=0, out_last=0, out_round=0, mixed_out=all zero, round_cnt=0, round key and stored key zero.
- State machine: NOKEY (key_valid=0) -> ACTIVE on key_load. ACTIVE stays ACTIVE; every key_load restarts the schedule. No transition back to NOKEY except on rst.
- in_ready = key_valid & !key_load & (!out_valid | out_ready). Combinational, no dependence on in_valid.
- Key load (any state):
  - stored_key <= key_in, rk <= key_in, round_cnt <= 0, key_valid <= 1.
  - Clears out_valid the same edge; any pending output is discarded.
  - key_load has priority over in_valid in the same cycle: the input is not accepted.
- Accept (in_valid & in_ready):
  - Next edge: mixed_out <= state_matrix XOR rk, bytewise with key byte 4*col+row.
  - Same edge: out_valid <= 1, out_round <= round_cnt, out_last <= (round_cnt==NR).
  - Latency 1 cycle; throughput 1 state/cycle when out_ready is held high.
- Schedule advance on accept:
  - round_cnt < NR: rk <= expand(rk, rcon[round_cnt+1]), round_cnt++.
  - round_cnt == NR: rk <= stored_key, round_cnt <= 0. The next block reuses the key without reload.
- expand(w0..w3, rc):
  - t = SubWord(RotWord(w3)) ^ {rc,24'h0}.
  - n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2.
  - w0 = rk[127:96].
  - SubWord applies the FIPS-197 S-box per byte, as a table or composite field; pure combinational, no extra cycle.
- rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
- Output hold: while out_valid & !out_ready, mixed_out, out_round and out_last hold stable.
- Output drain: out_valid falls the edge after handshake if no new accept.
- Simultaneous handshake: out_ready & in_valid in the same cycle gives back-to-back update with no bubble.
- in_valid with key_valid=0: ignored, in_ready=0, no state change.
- rst mid-block: all state returns to reset values the next edge; the partially processed block is lost.
- No combinational path from state_matrix to mixed_out.

Test Plan:
- Key load and round-0 output:
  - rst; key_load with key_in=2b7e151628aed2a6abf7158809cf4f3c; then in_valid with plaintext 3243f6a8885a308d313198a2e0370734.
  - Expected next cycle: out_valid=1, mixed_out=193de3bea0f4e22b9ac68d2ae9f84808, out_round=0, out_last=0.
- Key schedule walk:
  - Same key, feed 11 all-zero states back-to-back with out_ready=1.
  - Expected mixed_out sequence includes round1=a0fafe1788542cb123a339392a6c7605, round2=f2c295f27a96b9435935807a7359f67f, round10=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Round 10 has out_last=1. The 12th zero state returns 2b7e...4f3c with out_round=0.
- Backpressure:
  - Hold out_ready=0 after the round-0 accept.
  - Expected: in_ready=0, mixed_out and out_round stable for 5 cycles.
  - Raise out_ready with in_valid=1: next output is round 1 with no bubble and no duplicate.
- key_load priority:
  - Mid-schedule (round_cnt=4), assert key_load and in_valid together.
  - Expected: input not accepted, out_valid=0 next cycle, next accepted zero state outputs the new key_in with out_round=0.
- No key:
  - After rst, in_valid=1 for 3 cycles.
  - Expected: in_ready=0, out_valid=0, key_valid=0.
- Reset mid-operation:
  - rst during round 6 with out_valid=1.
  - Expected: next cycle out_valid=0, key_valid=0, mixed_out=0.

Source files
------------

// File: rtl/add_round_key_stage.sv
// AES-128 AddRoundKey stage with on-the-fly key schedule; 1-cycle latency, 1 state/cycle.
// Output register holds while out_valid & !out_ready; in_ready drops until it drains.
module add_round_key_stage #(
  parameter int NR = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    key_load,
  input  logic [127:0]            key_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [0:3][0:3][7:0]    state_matrix,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [0:3][0:3][7:0]    mixed_out,
  output logic [3:0]              out_round,
  output logic                    out_last,
  output logic                    key_valid
);

  localparam logic [3:0] NR_L = 4'(NR);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic {NOKEY, ACTIVE} state_t;

  typedef struct packed {
    logic [0:3][0:3][7:0] dat;
    logic [3:0]           rnd;
    logic                 last;
  } out_t;

  state_t         state, state_nxt;
  logic [127:0]   stored_key;
  logic [127:0]   rk;
  logic [127:0]   rk_nxt;
  logic [3:0]     round_cnt;
  logic           out_vld;
  out_t           out_q;
  logic           accept;
  logic [0:3][0:3][7:0] xored;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= NOKEY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      NOKEY:   if (key_load) state_nxt = ACTIVE;
      ACTIVE:  state_nxt = ACTIVE;
      default: state_nxt = NOKEY;
    endcase
  end

  always_comb begin
    key_valid = (state == ACTIVE);
  end

  assign in_ready = key_valid & ~key_load & (~out_vld | out_ready);
  assign accept   = in_valid & in_ready;

  // Next round key: rotate/substitute the last word, then ripple the XOR across the words.
  always_comb begin
    logic [31:0] w3, rot, sub, t, n0, n1, n2, n3;
    w3  = rk[31:0];
    rot = {w3[23:0], w3[31:24]};
    sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    t   = sub ^ {rcon(round_cnt + 4'd1), 24'h0};
    n0  = rk[127:96] ^ t;
    n1  = rk[95:64] ^ n0;
    n2  = rk[63:32] ^ n1;
    n3  = w3 ^ n2;
    rk_nxt = {n0, n1, n2, n3};
  end

  // Key byte 4*col+row lands on state[row][col].
  always_comb begin
    xored = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        xored[r][c] = state_matrix[r][c] ^ rk[127 - 8*(4*c + r) -: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stored_key <= '0;
      rk         <= '0;
      round_cnt  <= '0;
      out_vld    <= 1'b0;
      out_q      <= '0;
    end else if (key_load) begin
      stored_key <= key_in;
      rk         <= key_in;
      round_cnt  <= '0;
      out_vld    <= 1'b0;
    end else if (accept) begin
      out_vld    <= 1'b1;
      out_q.dat  <= xored;
      out_q.rnd  <= round_cnt;
      out_q.last <= (round_cnt == NR_L);
      if (round_cnt == NR_L) begin
        rk        <= stored_key;
        round_cnt <= '0;
      end else begin
        rk        <= rk_nxt;
        round_cnt <= round_cnt + 4'd1;
      end
    end else if (out_ready) begin
      out_vld <= 1'b0;
    end
  end

  assign out_valid = out_vld;
  assign mixed_out = out_q.dat;
  assign out_round = out_q.rnd;
  assign out_last  = out_q.last;

endmodule

// File: tb/tb_add_round_key_stage.sv
// Bench for add_round_key_stage: directed FIPS-197 vectors plus a spec-level reference model
// (GF(2^8)-derived S-box, word-wise key expansion) checked against the DUT every cycle.
module tb_add_round_key_stage;

  logic                 clk;
  logic                 rst;
  logic                 key_load;
  logic [127:0]         key_in;
  logic                 in_valid;
  logic                 in_ready;
  logic [0:3][0:3][7:0] state_matrix;
  logic                 out_valid;
  logic                 out_ready;
  logic [0:3][0:3][7:0] mixed_out;
  logic [3:0]           out_round;
  logic                 out_last;
  logic                 key_valid;

  add_round_key_stage #(.NR(10)) dut (
    .clk(clk), .rst(rst), .key_load(key_load), .key_in(key_in),
    .in_valid(in_valid), .in_ready(in_ready), .state_matrix(state_matrix),
    .out_valid(out_valid), .out_ready(out_ready), .mixed_out(mixed_out),
    .out_round(out_round), .out_last(out_last), .key_valid(key_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [127:0] mat2vec(input logic [0:3][0:3][7:0] m);
    logic [127:0] v;
    v = '0;
    for (int b = 0; b < 16; b++) v[127 - 8*b -: 8] = m[b % 4][b / 4];
    return v;
  endfunction

  function automatic logic [0:3][0:3][7:0] vec2mat(input logic [127:0] v);
    logic [0:3][0:3][7:0] m;
    m = '0;
    for (int b = 0; b < 16; b++) m[b % 4][b / 4] = v[127 - 8*b -: 8];
    return m;
  endfunction

  // Reference S-box built from the field inverse and affine map, not a lookup table.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int k);
    logic [15:0] d;
    d = {x, x} << k;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox_m(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gf_mul(inv, a);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  logic [127:0] m_rk [11];

  task automatic expand_model(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_m(tmp[31:24]), sbox_m(tmp[23:16]), sbox_m(tmp[15:8]), sbox_m(tmp[7:0])};
        tmp = tmp ^ {rc, 24'h0};
        rc  = xtime(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Cycle-level model of the stage's externally visible rules.
  logic         m_kv;
  int           m_cnt;
  logic         e_vld;
  logic [127:0] e_dat;
  logic [3:0]   e_rnd;
  logic         e_last;
  logic         m_acc;

  always @(posedge clk) begin
    if (rst) begin
      m_kv = 1'b0; m_cnt = 0; e_vld = 1'b0; e_dat = '0; e_rnd = '0; e_last = 1'b0;
    end else begin
      m_acc = m_kv && !key_load && (!e_vld || out_ready) && in_valid;
      if (key_load) begin
        expand_model(key_in);
        m_kv = 1'b1; m_cnt = 0; e_vld = 1'b0;
      end else if (m_acc) begin
        e_dat  = mat2vec(state_matrix) ^ m_rk[m_cnt];
        e_rnd  = 4'(m_cnt);
        e_last = (m_cnt == 10);
        e_vld  = 1'b1;
        m_cnt  = (m_cnt == 10) ? 0 : m_cnt + 1;
      end else if (e_vld && out_ready) begin
        e_vld = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", in_ready, m_kv && !key_load && (!e_vld || out_ready));
      chk("out_valid", out_valid, e_vld);
      chk("key_valid", key_valid, m_kv);
      if (e_vld) begin
        chk("mixed_out", mat2vec(mixed_out), e_dat);
        chk("out_round", out_round, e_rnd);
        chk("out_last", out_last, e_last);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [127:0] KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT   = 128'h3243f6a8885a308d313198a2e0370734;

  logic [127:0] got_dat [12];
  logic [3:0]   got_rnd [12];
  logic         got_last [12];
  logic [7:0]   sb_probe;

  initial begin
    rst = 1'b1; key_load = 1'b0; key_in = '0; in_valid = 1'b0;
    out_ready = 1'b1; state_matrix = '0;

    sb_probe = 8'h53;
    chk("model_sbox_53", sbox_m(sb_probe), 8'hed);

    repeat (2) step();
    chk("rst_key_valid", key_valid, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_out_round", out_round, 4'd0);
    chk("rst_mixed_out", mat2vec(mixed_out), 128'h0);
    chk_en = 1'b1;
    rst = 1'b0;

    // No key loaded: input must be refused.
    in_valid = 1'b1;
    state_matrix = vec2mat(PT);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("nokey_in_ready", in_ready, 1'b0);
      chk("nokey_out_valid", out_valid, 1'b0);
      chk("nokey_key_valid", key_valid, 1'b0);
    end
    in_valid = 1'b0;

    // Round 0 on the FIPS-197 example.
    key_load = 1'b1; key_in = KEY;
    step();
    key_load = 1'b0;
    chk("model_rk1", m_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("model_rk2", m_rk[2], 128'hf2c295f27a96b9435935807a7359f67f);
    chk("model_rk10", m_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    in_valid = 1'b1; state_matrix = vec2mat(PT);
    step();
    in_valid = 1'b0;
    chk("r0_out_valid", out_valid, 1'b1);
    chk("r0_mixed_out", mat2vec(mixed_out), 128'h193de3bea0f4e22b9ac68d2ae9f84808);
    chk("r0_out_round", out_round, 4'd0);
    chk("r0_out_last", out_last, 1'b0);
    step();

    // Full schedule walk with zero states, then wrap to round 0.
    key_load = 1'b1; key_in = KEY;
    step();
    key_load = 1'b0;
    state_matrix = '0;
    in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      got_dat[i] = mat2vec(mixed_out);
      got_rnd[i] = out_round;
      got_last[i] = out_last;
    end
    in_valid = 1'b0;
    chk("walk_r0", got_dat[0], KEY);
    chk("walk_r1", got_dat[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("walk_r2", got_dat[2], 128'hf2c295f27a96b9435935807a7359f67f);
    chk("walk_r10", got_dat[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("walk_r10_round", got_rnd[10], 4'd10);
    chk("walk_r10_last", got_last[10], 1'b1);
    chk("walk_r9_last", got_last[9], 1'b0);
    chk("walk_wrap_dat", got_dat[11], KEY);
    chk("walk_wrap_round", got_rnd[11], 4'd0);
    step();

    // Backpressure: output must hold and input must stall.
    key_load = 1'b1; key_in = KEY;
    step();
    key_load = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b1; state_matrix = '0;
    step();
    for (int i = 0; i < 5; i++) begin
      state_matrix = vec2mat({$urandom, $urandom, $urandom, $urandom});
      step();
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_hold_dat", mat2vec(mixed_out), KEY);
      chk("bp_hold_round", out_round, 4'd0);
    end
    out_ready = 1'b1; state_matrix = '0;
    step();
    in_valid = 1'b0;
    chk("bp_release_dat", mat2vec(mixed_out), 128'ha0fafe1788542cb123a339392a6c7605);
    chk("bp_release_round", out_round, 4'd1);
    chk("bp_release_valid", out_valid, 1'b1);
    step();

    // key_load wins over a simultaneous input mid-schedule.
    key_load = 1'b1; key_in = KEY;
    step();
    key_load = 1'b0;
    in_valid = 1'b1; state_matrix = '0;
    repeat (4) step();
    key_load = 1'b1; key_in = KEY2;
    step();
    chk("prio_out_valid", out_valid, 1'b0);
    key_load = 1'b0;
    step();
    in_valid = 1'b0;
    chk("prio_new_key", mat2vec(mixed_out), KEY2);
    chk("prio_round", out_round, 4'd0);
    step();

    // Reset while round 6 is presented.
    key_load = 1'b1; key_in = KEY;
    step();
    key_load = 1'b0;
    in_valid = 1'b1; state_matrix = '0;
    repeat (7) step();
    in_valid = 1'b0;
    chk("mid_round6", out_round, 4'd6);
    chk("mid_valid6", out_valid, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_key_valid", key_valid, 1'b0);
    chk("mid_rst_mixed_out", mat2vec(mixed_out), 128'h0);

    // Mixed traffic with random data, stalls and occasional rekeying.
    key_load = 1'b1; key_in = {$urandom, $urandom, $urandom, $urandom};
    step();
    key_load = 1'b0;
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      key_load = ($urandom_range(0, 39) == 0);
      key_in = {$urandom, $urandom, $urandom, $urandom};
      state_matrix = vec2mat({$urandom, $urandom, $urandom, $urandom});
      step();
    end
    key_load = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
